shamt_xform_pipe: RTL and testbench
===================================

Name: shamt_xform_pipe

Overview:
Parametrised, pipelined successor to the 4-bit shift-amount complement lookup. Converts an IN_W-bit shift amount into an OUT_W-bit operand under one of four per-transaction modes:
- pass
- modular negate (rotate-right to rotate-left)
- bitwise invert
- sign-extended negate

Sits between decode and the shifter/ALU operand mux. Uses a valid/ready handshake and a 2-entry skid buffer, so the shifter can stall without dropping amounts.

Parameters:
- IN_W, 4, width of input amount; legal range 1..OUT_W.
- OUT_W, 16, width of output operand; OUT_W >= IN_W.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has a transaction.
- in_ready  out  1  block can accept; a transfer happens when in_valid && in_ready.
- in_data  in  IN_W  shift amount.
- in_mode  in  2  transform select, sampled with in_data.
- out_valid  out  1  out_data/out_zero are valid.
- out_ready  in  1  downstream accepts; a transfer happens when out_valid && out_ready.
- out_data  out  OUT_W  transformed operand.
- out_zero  out  1  out_data == 0, i.e. no shift required.

Behaviour:
- Transform f(mode,x), computed combinationally at acceptance and stored already formatted:
  - 2'b00 PASS: zero-extend x.
  - 2'b01 MODNEG: zero-extend((2^IN_W - x) mod 2^IN_W). Gives x=0 -> 0, x=1 -> 2^IN_W-1, x=2^(IN_W-1) -> 2^(IN_W-1). With IN_W=4, OUT_W=16 this matches the legacy table exactly.
  - 2'b10 INV: zero-extend(~x).
  - 2'b11 NEG_SX: (2^OUT_W - zext(x)) mod 2^OUT_W. Gives x=0 -> 0, x=1 -> all ones.
- out_zero is registered alongside out_data.
- Storage: main register (drives outputs) plus skid register. Occupancy states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- Transitions (acc = input transfer, pop = output transfer):
  - EMPTY: acc -> ONE, item into main.
  - ONE: acc && pop -> ONE, new item into main. acc && !pop -> FULL, new item into skid. pop && !acc -> EMPTY. Neither -> ONE.
  - FULL: pop -> ONE, skid moves to main. No acc is possible in FULL.
- Latency 1 cycle: an item accepted at edge N is visible on out_data after edge N.
- Throughput 1 per cycle when out_ready is held high.
- in_ready is a registered function of state. It never depends combinationally on out_ready or in_valid.
- While out_valid && !out_ready, out_data and out_zero hold stable. Items are delivered strictly in acceptance order; none are dropped or duplicated.
- in_valid without in_ready: block ignores in_data and in_mode. Upstream holds them.
- Reset (rst_n low, any cycle, including mid-stall with FULL):
  - state -> EMPTY; out_valid=0, out_data=0, out_zero=0; skid cleared; in_ready=0 while rst_n is low.
  - First edge after release: in_ready=1. No transfer occurs on the release edge.
- Illegal parameters (IN_W > OUT_W or IN_W < 1) are caught by an elaboration-time check.

Decomposition:
- Shared package holds:
  - mode constants MODE_PASS=2'b00, MODE_MODNEG=2'b01, MODE_INV=2'b10, MODE_NEGSX=2'b11;
  - occupancy encoding OCC_EMPTY, OCC_ONE, OCC_FULL.
- One natural sub-module: shamt_xform_core. Combinational f(mode,x) plus zero flag, parametrised IN_W/OUT_W. Reusable by the shifter's bypass path.
- Top level holds the handshake FSM and registers only.

Test Plan:
- Reset, then PASS/MODNEG/INV/NEGSX on x=4'h3, out_ready=1 -> out_data 16'h0003, 16'h000D, 16'h000C, 16'hFFFD; one per cycle, latency 1.
- MODNEG sweep x=0..15, defaults -> 0,F,E,...,1 matching legacy table; out_zero=1 only for x=0.
- out_ready=0, send x=1 then x=2 (MODNEG) -> FULL, in_ready=0, out_data stable 16'h000F. Raise out_ready -> 16'h000F then 16'h000E, in_ready back to 1.
- Random in_valid/out_ready toggling for 1000 items, scoreboard -> in-order, no loss or duplication, out_data stable under stall.
- Assert rst_n low while FULL -> out_valid=0, out_data=0, in_ready=0 immediately. After release, a new item x=5 PASS -> 16'h0005 with no stale items.
- IN_W=5, OUT_W=8: MODNEG x=1 -> 8'h1F; NEGSX x=1 -> 8'hFF; INV x=0 -> 8'h1F.

Source files
------------

// File: rtl/shamt_xform_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shamt_xform_pipe_pkg
// Description : Shared mode constants and occupancy encoding for the
//               shift-amount transform pipeline and its combinational core.
// Revision    : 1.0 - initial release
// ============================================================================
package shamt_xform_pipe_pkg;

  // Transform selectors, sampled alongside the shift amount.
  localparam logic [1:0] MODE_PASS   = 2'b00;
  localparam logic [1:0] MODE_MODNEG = 2'b01;
  localparam logic [1:0] MODE_INV    = 2'b10;
  localparam logic [1:0] MODE_NEGSX  = 2'b11;

  // Occupancy of the main + skid register pair.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_FULL  = 2'b10
  } occ_t;

endpackage
`default_nettype wire

// File: rtl/shamt_xform_core.sv
`default_nettype none
// ============================================================================
// Module      : shamt_xform_core
// Description : Combinational shift-amount transform f(mode, x) with zero
//               flag. Parametrised input/output widths; also usable by the
//               shifter bypass path.
// Revision    : 1.0 - initial release
// ============================================================================
module shamt_xform_core
  import shamt_xform_pipe_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] data,
  output logic             zero
);

  // Output must be at least as wide as the amount, and the amount non-empty.
  generate
    if ((IN_W < 1) || (IN_W > OUT_W)) begin : g_bad_params
      $error("shamt_xform_core: illegal widths, need 1 <= IN_W <= OUT_W");
    end
  endgenerate

  logic [OUT_W-1:0] x_ext;
  logic [IN_W-1:0]  x_neg;
  logic [IN_W-1:0]  x_inv;

  // Select the transform; negation in IN_W bits wraps modulo 2^IN_W,
  // negation in OUT_W bits gives the sign-extended form.
  always_comb begin
    x_ext = OUT_W'(x);
    x_neg = IN_W'(0) - x;
    x_inv = ~x;
    data  = x_ext;
    case (mode)
      MODE_PASS:   data = x_ext;
      MODE_MODNEG: data = OUT_W'(x_neg);
      MODE_INV:    data = OUT_W'(x_inv);
      MODE_NEGSX:  data = OUT_W'(0) - x_ext;
      default:     data = x_ext;
    endcase
    zero = (data == '0);
  end

endmodule
`default_nettype wire

// File: rtl/shamt_xform_pipe.sv
`default_nettype none
// ============================================================================
// Module      : shamt_xform_pipe
// Description : Valid/ready pipeline stage around shamt_xform_core with a
//               main output register and one skid register, so downstream
//               can stall without losing accepted amounts.
// Revision    : 1.0 - initial release
// ============================================================================
module shamt_xform_pipe
  import shamt_xform_pipe_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_zero
);

  occ_t             state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic             skid_zero_q, skid_zero_d;

  logic [OUT_W-1:0] xf_data;
  logic             xf_zero;
  logic             acc;
  logic             pop;

  // The transform is applied before storage so the registers hold the
  // finished operand and its zero flag.
  shamt_xform_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .mode (in_mode),
    .x    (in_data),
    .data (xf_data),
    .zero (xf_zero)
  );

  assign out_valid = (state_q != OCC_EMPTY);
  assign in_ready  = in_ready_q;
  assign out_data  = data_q;
  assign out_zero  = zero_q;
  assign acc       = in_valid && in_ready_q;
  assign pop       = out_valid && out_ready;

  // Occupancy next-state and register steering; in_ready is precomputed from
  // the next state so it is a pure flop output.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    zero_d      = zero_q;
    skid_data_d = skid_data_q;
    skid_zero_d = skid_zero_q;
    case (state_q)
      OCC_EMPTY: begin
        if (acc) begin
          data_d  = xf_data;
          zero_d  = xf_zero;
          state_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (acc && pop) begin
          data_d = xf_data;
          zero_d = xf_zero;
        end else if (acc) begin
          skid_data_d = xf_data;
          skid_zero_d = xf_zero;
          state_d     = OCC_FULL;
        end else if (pop) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          data_d  = skid_data_q;
          zero_d  = skid_zero_q;
          state_d = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    in_ready_d = (state_d != OCC_FULL);
  end

  // State and storage registers; reset clears everything and holds in_ready low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OCC_EMPTY;
      in_ready_q  <= 1'b0;
      data_q      <= '0;
      zero_q      <= 1'b0;
      skid_data_q <= '0;
      skid_zero_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      data_q      <= data_d;
      zero_q      <= zero_d;
      skid_data_q <= skid_data_d;
      skid_zero_q <= skid_zero_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shamt_xform_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_shamt_xform_pipe
// Description : Self-checking bench for shamt_xform_pipe: directed cases plus
//               randomized handshake traffic against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shamt_xform_pipe;
  import shamt_xform_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_zero;

  logic        b_in_valid;
  logic        b_in_ready;
  logic [4:0]  b_in_data;
  logic [1:0]  b_in_mode;
  logic        b_out_valid;
  logic [7:0]  b_out_data;
  logic        b_out_zero;

  int n_cmp = 0;
  int n_err = 0;
  int q[$];

  always #5 clk = ~clk;

  shamt_xform_pipe #(.IN_W(4), .OUT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  shamt_xform_pipe #(.IN_W(5), .OUT_W(8)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_mode   (b_in_mode),
    .out_valid (b_out_valid),
    .out_ready (1'b1),
    .out_data  (b_out_data),
    .out_zero  (b_out_zero)
  );

  // Reference transform from the arithmetic definitions.
  function automatic int model_f(input int iw, input int ow, input int m, input int x);
    int mi, mo;
    mi = 1 << iw;
    mo = 1 << ow;
    case (m)
      0:       return x;
      1:       return (mi - x) % mi;
      2:       return mi - 1 - x;
      default: return (mo - x) % mo;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of traffic on the 4/16 instance, checked against a 2-deep FIFO model.
  task automatic cycle(input logic v, input logic [3:0] d, input logic [1:0] m, input logic r);
    bit acc, pop;
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    out_ready = r;
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("out_data", {16'd0, out_data}, q[0]);
      chk("out_zero", {31'd0, out_zero}, {31'd0, q[0] == 0});
    end
    acc = v && (q.size() < 2);
    pop = (q.size() != 0) && r;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(model_f(4, 16, int'(m), int'(d)));
  endtask

  initial begin
    int legacy[16];
    int accepted;
    int cyc;
    legacy = '{0, 15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1};

    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_mode = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, out_data}, 32'd0);
    chk("rst_out_zero", {31'd0, out_zero}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);

    // Four modes on x=3, back to back.
    cycle(1'b1, 4'h3, MODE_PASS, 1'b1);
    chk("pass_x3", {16'd0, out_data}, 32'h0003);
    cycle(1'b1, 4'h3, MODE_MODNEG, 1'b1);
    chk("modneg_x3", {16'd0, out_data}, 32'h000D);
    cycle(1'b1, 4'h3, MODE_INV, 1'b1);
    chk("inv_x3", {16'd0, out_data}, 32'h000C);
    cycle(1'b1, 4'h3, MODE_NEGSX, 1'b1);
    chk("negsx_x3", {16'd0, out_data}, 32'hFFFD);
    cycle(1'b0, 4'h0, MODE_PASS, 1'b1);

    // Legacy MODNEG table.
    for (int x = 0; x < 16; x++) begin
      cycle(1'b1, 4'(x), MODE_MODNEG, 1'b1);
      chk("legacy_data", {16'd0, out_data}, legacy[x]);
      chk("legacy_zero", {31'd0, out_zero}, {31'd0, x == 0});
    end
    cycle(1'b0, 4'h0, MODE_PASS, 1'b1);

    // Fill to FULL under stall, then drain.
    cycle(1'b1, 4'h1, MODE_MODNEG, 1'b0);
    cycle(1'b1, 4'h2, MODE_MODNEG, 1'b0);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("full_out_data", {16'd0, out_data}, 32'h000F);
    cycle(1'b1, 4'h7, MODE_PASS, 1'b0);
    chk("stall_stable", {16'd0, out_data}, 32'h000F);
    cycle(1'b0, 4'h0, MODE_PASS, 1'b1);
    chk("drain_second", {16'd0, out_data}, 32'h000E);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd1);
    cycle(1'b0, 4'h0, MODE_PASS, 1'b1);
    cycle(1'b0, 4'h0, MODE_PASS, 1'b1);

    // Random traffic, 1000 accepted items.
    accepted = 0;
    cyc = 0;
    while (accepted < 1000 && cyc < 20000) begin
      logic v, r;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      if (v && q.size() < 2) accepted++;
      cycle(v, 4'($urandom), 2'($urandom), r);
      cyc++;
    end
    chk("random_budget", {31'd0, accepted >= 1000}, 32'd1);
    cyc = 0;
    while (q.size() != 0 && cyc < 20) begin
      cycle(1'b0, 4'h0, MODE_PASS, 1'b1);
      cyc++;
    end
    cycle(1'b0, 4'h0, MODE_PASS, 1'b1);

    // Reset in the middle of a FULL stall.
    cycle(1'b1, 4'h7, MODE_PASS, 1'b0);
    cycle(1'b1, 4'h9, MODE_INV, 1'b0);
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_data", {16'd0, out_data}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    q.delete();
    in_valid = 1'b1; in_data = 4'h5; in_mode = MODE_PASS; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("inrst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("release_no_xfer", {31'd0, out_valid}, 32'd0);
    chk("release_ready2", {31'd0, in_ready}, 32'd1);
    cycle(1'b1, 4'h5, MODE_PASS, 1'b1);
    chk("post_rst_item", {16'd0, out_data}, 32'h0005);
    cycle(1'b0, 4'h0, MODE_PASS, 1'b1);
    cycle(1'b0, 4'h0, MODE_PASS, 1'b1);

    // Second parametrisation: IN_W=5, OUT_W=8.
    b_in_valid = 1'b1; b_in_data = 5'd1; b_in_mode = MODE_MODNEG;
    @(posedge clk); #1;
    chk("b_modneg_x1", {24'd0, b_out_data}, 32'h1F);
    chk("b_modneg_model", {24'd0, b_out_data}, model_f(5, 8, 1, 1));
    b_in_data = 5'd1; b_in_mode = MODE_NEGSX;
    @(posedge clk); #1;
    chk("b_negsx_x1", {24'd0, b_out_data}, 32'hFF);
    b_in_data = 5'd0; b_in_mode = MODE_INV;
    @(posedge clk); #1;
    chk("b_inv_x0", {24'd0, b_out_data}, 32'h1F);
    chk("b_inv_zero", {31'd0, b_out_zero}, 32'd0);
    b_in_data = 5'd0; b_in_mode = MODE_PASS;
    @(posedge clk); #1;
    chk("b_pass_zero", {31'd0, b_out_zero}, 32'd1);
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b_empty", {31'd0, b_out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
